// File: rtl/nv_nvdla_fifo_pkg.sv
// Shared constants and helpers for the parametrised NVDLA valid/ready FIFO.
// Holds parameter legality limits, the count-width helper and the count-update encoding.
package nv_nvdla_fifo_pkg;

   localparam int FIFO_DEPTH_MIN    = 4;
   localparam int FIFO_DEPTH_MAX    = 1024;
   localparam int FIFO_WIDTH_MIN    = 1;
   localparam int FIFO_AFULL_MARGIN = 4;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   // A count that must reach DEPTH itself needs one bit more than an address.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit depth_is_legal(input int depth);
      return (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX) &&
             ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit width_is_legal(input int width);
      return width >= FIFO_WIDTH_MIN;
   endfunction

   // Simultaneous increment and decrement cancel out.
   function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
      cnt_op_e op;
      op = CNT_HOLD;
      if (inc && !dec) begin
         op = CNT_INC;
      end else if (dec && !inc) begin
         op = CNT_DEC;
      end
      return op;
   endfunction

endpackage

// File: rtl/nv_nvdla_fifo_ram.sv
// One-write, one-read synchronous RAM wrapper; the read register doubles as the FIFO output stage.
// rd data only changes when the read enable is high, so a stalled consumer sees a stable word.
module nv_nvdla_fifo_ram
   import nv_nvdla_fifo_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int WIDTH = 11,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [31:0]      pwrbus_ram_pd,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] di,
   input  logic             re,
   input  logic [AW-1:0]    ra,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             unused_pwrbus;

   // Power-down controls belong to a hard macro; the behavioural array ignores them.
   assign unused_pwrbus = ^pwrbus_ram_pd;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= di;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         dout <= mem[ra];
      end
   end

`ifdef ASSERT_ON
   generate
      if (!depth_is_legal(DEPTH) || !width_is_legal(WIDTH)) begin : g_param_check
         $error("nv_nvdla_fifo_ram: illegal DEPTH/WIDTH");
      end
   endgenerate
`endif

endmodule

// File: rtl/nv_nvdla_param_fifo.sv
// Parametrised single-clock valid/ready FIFO with runtime write limit, occupancy count,
// almost-full flag and synchronous flush. Fall-through latency is two cycles.
module nv_nvdla_param_fifo
   import nv_nvdla_fifo_pkg::*;
#(
   parameter int WIDTH    = 11,
   parameter int DEPTH    = 128,
   parameter int AFULL_TH = DEPTH - FIFO_AFULL_MARGIN,
   localparam int CW      = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             wr_req,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_req,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   input  logic [CW-1:0]    wr_limit,
   output logic [CW-1:0]    wr_count,
   output logic             almost_full,
   input  logic [31:0]      pwrbus_ram_pd
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [AW-1:0] wr_adr;
   logic [AW-1:0] rd_adr;
   logic [CW-1:0] ram_count;
   logic [CW-1:0] wr_count_next;
   logic [CW-1:0] ram_count_next;
   logic [CW-1:0] eff_limit;
   logic          accept;
   logic          pop;
   logic          load;
   logic          slcg_en;
   cnt_op_e       wr_op;
   cnt_op_e       ram_op;

   assign accept = wr_req && wr_ready;
   assign pop    = rd_req && rd_ready;

   // ram_count tracks words in RAM not yet moved to the output register; refill whenever
   // the output register is empty or being drained this cycle.
   assign load = (ram_count != '0) && (!rd_req || rd_ready) && !flush;

   assign wr_op  = cnt_op(accept, pop);
   assign ram_op = cnt_op(accept, load);

   always_comb begin
      eff_limit = wr_limit;
      if ((wr_limit == '0) || (wr_limit > DEPTH_C)) begin
         eff_limit = DEPTH_C;
      end
   end

   always_comb begin
      wr_count_next = wr_count;
      case (wr_op)
         CNT_INC: wr_count_next = wr_count + ONE_C;
         CNT_DEC: wr_count_next = wr_count - ONE_C;
         default: wr_count_next = wr_count;
      endcase
   end

   always_comb begin
      ram_count_next = ram_count;
      case (ram_op)
         CNT_INC: ram_count_next = ram_count + ONE_C;
         CNT_DEC: ram_count_next = ram_count - ONE_C;
         default: ram_count_next = ram_count;
      endcase
   end

`ifdef NVDLA_FIFO_SLCG_BYPASS
   assign slcg_en = 1'b1;
`else
   assign slcg_en = flush || accept || pop || load;
`endif

   // wr_ready is re-evaluated every cycle so a lowered wr_limit takes effect without traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_adr    <= '0;
         rd_adr    <= '0;
         wr_count  <= '0;
         ram_count <= '0;
         rd_req    <= 1'b0;
         wr_ready  <= 1'b0;
      end else begin
         wr_ready <= (wr_count_next < eff_limit) && !flush;
         if (slcg_en) begin
            if (flush) begin
               wr_adr    <= '0;
               rd_adr    <= '0;
               wr_count  <= '0;
               ram_count <= '0;
               rd_req    <= 1'b0;
            end else begin
               if (accept) begin
                  wr_adr <= wr_adr + AW'(1);
               end
               if (load) begin
                  rd_adr <= rd_adr + AW'(1);
               end
               wr_count  <= wr_count_next;
               ram_count <= ram_count_next;
               if (load) begin
                  rd_req <= 1'b1;
               end else if (pop) begin
                  rd_req <= 1'b0;
               end
            end
         end
      end
   end

   assign almost_full = (wr_count >= AFULL_C);

   nv_nvdla_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk           (clk),
      .pwrbus_ram_pd (pwrbus_ram_pd),
      .we            (accept && !flush),
      .wa            (wr_adr),
      .di            (wr_data),
      .re            (load),
      .ra            (rd_adr),
      .dout          (rd_data)
   );

`ifdef ASSERT_ON
   generate
      if (!depth_is_legal(DEPTH) || !width_is_legal(WIDTH)) begin : g_param_check
         $error("nv_nvdla_param_fifo: illegal DEPTH/WIDTH");
      end
   endgenerate

   a_count_bound: assert property (@(posedge clk) disable iff (reset)
      wr_count <= DEPTH_C);

   a_stall_stable: assert property (@(posedge clk) disable iff (reset)
      (rd_req && !rd_ready && !flush) |=> (rd_req && $stable(rd_data)));

   a_no_blind_write: assert property (@(posedge clk) disable iff (reset)
      (accept && !flush) |-> wr_ready);
`endif

endmodule

// File: tb/tb_nv_nvdla_param_fifo.sv
// Directed self-checking bench for nv_nvdla_param_fifo (DEPTH=128, WIDTH=11).
// A queue of accepted words checks every pop for order, loss and duplication.
module tb_nv_nvdla_param_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        wr_req;
   logic        wr_ready;
   logic [10:0] wr_data;
   logic        rd_req;
   logic        rd_ready;
   logic [10:0] rd_data;
   logic [7:0]  wr_limit;
   logic [7:0]  wr_count;
   logic        almost_full;
   logic [31:0] pwrbus_ram_pd;

   int          testCount = 0;
   int          failCount = 0;
   logic [10:0] model[$];

   nv_nvdla_param_fifo #(.WIDTH(11), .DEPTH(128)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .wr_req        (wr_req),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_req        (rd_req),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .wr_limit      (wr_limit),
      .wr_count      (wr_count),
      .almost_full   (almost_full),
      .pwrbus_ram_pd (pwrbus_ram_pd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, then lands 1ns after the next rising edge.
   task automatic applyStimulus(input logic wq, input logic [10:0] wd, input logic rr, input logic fl);
      logic        acc;
      logic        pp;
      logic [10:0] pd;
      logic [10:0] exp;
      wr_req   = wq;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      acc = wq && wr_ready;
      pp  = rd_req && rr;
      pd  = rd_data;
      @(posedge clk);
      #1;
      if (pp) begin
         checkOutput("pop_has_entry", 32'(model.size() != 0), 32'd1);
         if (model.size() != 0) begin
            exp = model.pop_front();
            checkOutput("pop_data", 32'(pd), 32'(exp));
         end
      end
      if (fl || reset) begin
         model.delete();
      end else if (acc) begin
         model.push_back(wd);
      end
   endtask

   task automatic fillWords(input int n, input logic [10:0] base);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, base + 11'(i), 1'b0, 1'b0);
      end
   endtask

   task automatic drainAll();
      for (int k = 0; k < 300 && model.size() != 0; k++) begin
         applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      end
      checkOutput("drain_empty", 32'(model.size() == 0), 32'd1);
      checkOutput("drain_rd_req", 32'(rd_req), 32'd0);
      checkOutput("drain_wr_count", 32'(wr_count), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      wr_req = 1'b0;
      wr_data = '0;
      rd_ready = 1'b0;
      wr_limit = 8'd0;
      pwrbus_ram_pd = 32'd0;

      // Reset state
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
      checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("rst_release_wr_ready", 32'(wr_ready), 32'd1);

      // Basic latency: accept in N, visible in N+2, gone in N+3
      applyStimulus(1'b1, 11'h5A5, 1'b1, 1'b0);
      checkOutput("lat_n1_rd_req", 32'(rd_req), 32'd0);
      checkOutput("lat_n1_wr_count", 32'(wr_count), 32'd1);
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      checkOutput("lat_n2_rd_req", 32'(rd_req), 32'd1);
      checkOutput("lat_n2_rd_data", 32'(rd_data), 32'h5A5);
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      checkOutput("lat_n3_rd_req", 32'(rd_req), 32'd0);
      checkOutput("lat_n3_wr_count", 32'(wr_count), 32'd0);

      // Fill to 128 with the consumer stalled
      for (int i = 0; i < 128; i++) begin
         applyStimulus(1'b1, 11'(i) ^ 11'h2AA, 1'b0, 1'b0);
         checkOutput("fill_wr_count", 32'(wr_count), 32'(i + 1));
         checkOutput("fill_wr_ready", 32'(wr_ready), 32'(i + 1 < 128));
         if (i == 122) checkOutput("fill_afull_123", 32'(almost_full), 32'd0);
         if (i == 123) checkOutput("fill_afull_124", 32'(almost_full), 32'd1);
      end
      applyStimulus(1'b1, 11'h007, 1'b0, 1'b0);
      checkOutput("full_wr_count", 32'(wr_count), 32'd128);
      checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("full_almost_full", 32'(almost_full), 32'd1);

      // Mixed traffic across pointer wrap
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'(i % 3 != 0), 11'(i + 256), 1'(i % 4 != 1), 1'b0);
      end
      drainAll();

      // Runtime limit of 16, then lowered to 8 with 16 stored
      wr_limit = 8'd16;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 11'(k + 11'h40), 1'b0, 1'b0);
         checkOutput("lim16_wr_ready", 32'(wr_ready), 32'(k < 16));
      end
      applyStimulus(1'b1, 11'h0EE, 1'b0, 1'b0);
      checkOutput("lim16_wr_count", 32'(wr_count), 32'd16);
      wr_limit = 8'd8;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("lim8_wr_ready", 32'(wr_ready), 32'd0);
      for (int p = 1; p <= 9; p++) begin
         applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
         checkOutput("lim8_wr_count", 32'(wr_count), 32'(16 - p));
         checkOutput("lim8_wr_ready", 32'(wr_ready), 32'(16 - p < 8));
      end
      wr_limit = 8'd0;
      drainAll();
      fillWords(128, 11'h600);
      checkOutput("lim0_wr_count", 32'(wr_count), 32'd128);
      checkOutput("lim0_wr_ready", 32'(wr_ready), 32'd0);
      drainAll();

      // Consumer stall: rd_ready 0,0,1 on word 0x123
      applyStimulus(1'b1, 11'h123, 1'b0, 1'b0);
      applyStimulus(1'b1, 11'h124, 1'b0, 1'b0);
      checkOutput("stall_c0_data", 32'(rd_data), 32'h123);
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("stall_c1_data", 32'(rd_data), 32'h123);
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("stall_c2_req", 32'(rd_req), 32'd1);
      checkOutput("stall_c2_data", 32'(rd_data), 32'h123);
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      checkOutput("stall_next_data", 32'(rd_data), 32'h124);
      drainAll();

      // Flush with simultaneous write and pop
      fillWords(40, 11'h200);
      checkOutput("flush_pre_count", 32'(wr_count), 32'd40);
      applyStimulus(1'b1, 11'h3C3, 1'b1, 1'b1);
      checkOutput("flush_f1_wr_count", 32'(wr_count), 32'd0);
      checkOutput("flush_f1_rd_req", 32'(rd_req), 32'd0);
      checkOutput("flush_f1_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("flush_f1_afull", 32'(almost_full), 32'd0);
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      checkOutput("flush_f2_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("flush_f2_rd_req", 32'(rd_req), 32'd0);
      applyStimulus(1'b1, 11'h055, 1'b1, 1'b0);
      checkOutput("flush_post_n1_rd_req", 32'(rd_req), 32'd0);
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0);
      checkOutput("flush_post_rd_data", 32'(rd_data), 32'h055);
      drainAll();

      // Reset mid-stream with 50 stored
      fillWords(50, 11'h480);
      reset = 1'b1;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("mrst_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("mrst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("mrst_wr_count", 32'(wr_count), 32'd0);
      checkOutput("mrst_almost_full", 32'(almost_full), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("mrst_release_wr_ready", 32'(wr_ready), 32'd1);
      applyStimulus(1'b1, 11'h7FF, 1'b0, 1'b0);
      checkOutput("mrst_n1_rd_req", 32'(rd_req), 32'd0);
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
      checkOutput("mrst_n2_rd_req", 32'(rd_req), 32'd1);
      checkOutput("mrst_n2_rd_data", 32'(rd_data), 32'h7FF);
      drainAll();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
